// File: rtl/bcd_timer_if.sv
// Control/status bundle for bcd_timer: command strobes and preset in, BCD count and status out.
interface bcd_timer_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  tick;
  logic                  start;
  logic                  stop;
  logic                  load;
  logic [DIGITS*4-1:0]   load_val;
  logic                  dir;
  logic [DIGITS*4-1:0]   count;
  logic [DIGITS-1:0]     blank;
  logic                  running;
  logic                  done;

  modport master (
    output tick, start, stop, load, load_val, dir,
    input  count, blank, running, done
  );

  modport slave (
    input  tick, start, stop, load, load_val, dir,
    output count, blank, running, done
  );
endinterface

// File: rtl/bcd_timer.sv
// Multi-digit BCD up/down timer with preset, target match and optional auto-reload.
// Define BCD_TIMER_BLANK_EN to enable the leading-zero blank mask.
module bcd_timer #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned RELOAD = 0
) (
  input  logic      clk,
  input  logic      rst,
  bcd_timer_if.slave bus
);

  localparam int unsigned W = DIGITS * 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic           done_q, done_d;
  // Set after a tick reaches terminal in reload mode; the next tick reloads instead of stepping.
  logic           rld_q, rld_d;

  logic [W-1:0]   clamp_val, inc_val, dec_val, step_val, term_val;
  logic           carry, borrow;

  always_comb begin
    clamp_val = bus.load_val;
    inc_val   = count_q;
    dec_val   = count_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
      if (carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    // Counting down saturates at zero rather than wrapping.
    if (count_q == '0) dec_val = '0;
    step_val = bus.dir ? inc_val : dec_val;
    term_val = bus.dir ? tgt_q : '0;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    rld_d   = rld_q;
    if (bus.load) begin
      count_d = clamp_val;
      tgt_d   = clamp_val;
      state_d = StIdle;
      rld_d   = 1'b0;
    end else if (bus.stop) begin
      if (state_q == StRun) begin
        state_d = StIdle;
        rld_d   = 1'b0;
      end
    end else if (bus.start) begin
      if (state_q != StRun) begin
        state_d = StRun;
        rld_d   = 1'b0;
      end
    end else if (bus.tick && state_q == StRun) begin
      if (RELOAD != 0 && rld_q) begin
        count_d = bus.dir ? '0 : tgt_q;
        rld_d   = 1'b0;
      end else begin
        count_d = step_val;
        if (step_val == term_val) begin
          done_d = 1'b1;
          if (RELOAD != 0) rld_d = 1'b1;
          else             state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      rld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      rld_q   <= rld_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == StRun);
  assign bus.done    = done_q;

`ifdef BCD_TIMER_BLANK_EN
  // Digit 0 always shows so that a zero count still displays "0".
  logic hi_zero;
  always_comb begin
    bus.blank = '0;
    hi_zero   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (count_q[4*i +: 4] == 4'd0);
      bus.blank[i] = hi_zero;
    end
  end
`else
  assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// Directed self-checking bench for bcd_timer: three instances cover 6-digit stop,
// 3-digit stop and 3-digit reload configurations.
module tb_bcd_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_timer_if #(.DIGITS(6)) if6 ();
  bcd_timer_if #(.DIGITS(3)) if3 ();
  bcd_timer_if #(.DIGITS(3)) if3r ();

  bcd_timer #(.DIGITS(6), .RELOAD(0)) u6   (.clk(clk), .rst(rst), .bus(if6));
  bcd_timer #(.DIGITS(3), .RELOAD(0)) u3   (.clk(clk), .rst(rst), .bus(if3));
  bcd_timer #(.DIGITS(3), .RELOAD(1)) u3r  (.clk(clk), .rst(rst), .bus(if3r));

`ifdef BCD_TIMER_BLANK_EN
  localparam logic [5:0] BlankZero6 = 6'b111110;
  localparam logic [5:0] Blank450   = 6'b111000;
  localparam logic [5:0] Blank105   = 6'b111000;
`else
  localparam logic [5:0] BlankZero6 = 6'b000000;
  localparam logic [5:0] Blank450   = 6'b000000;
  localparam logic [5:0] Blank105   = 6'b000000;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {if6.tick, if6.start, if6.stop, if6.load, if6.dir} = '0;
    {if3.tick, if3.start, if3.stop, if3.load, if3.dir} = '0;
    {if3r.tick, if3r.start, if3r.stop, if3r.load, if3r.dir} = '0;
    if6.load_val = '0;
    if3.load_val = '0;
    if3r.load_val = '0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (if6.count !== 24'h0) begin bad++;
      $display("FAIL reset_count6 got=%h want=000000", if6.count); end
    total++; if (if6.running !== 1'b0 || if6.done !== 1'b0) begin bad++;
      $display("FAIL reset_flags6 got=%b%b want=00", if6.running, if6.done); end
    total++; if (if6.blank !== BlankZero6) begin bad++;
      $display("FAIL reset_blank6 got=%b want=%b", if6.blank, BlankZero6); end
    total++; if (if3r.count !== 12'h0 || if3r.running !== 1'b0) begin bad++;
      $display("FAIL reset_3r got=%h/%b want=000/0", if3r.count, if3r.running); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_down6();
    if6.load = 1'b1; if6.load_val = 24'h000105;
    step();
    total++; if (if6.count !== 24'h000105 || if6.running !== 1'b0) begin bad++;
      $display("FAIL load6 got=%h/%b want=000105/0", if6.count, if6.running); end
    total++; if (if6.blank !== Blank105) begin bad++;
      $display("FAIL blank105 got=%b want=%b", if6.blank, Blank105); end
    if6.load = 1'b0; if6.start = 1'b1;
    step();
    total++; if (if6.running !== 1'b1 || if6.count !== 24'h000105) begin bad++;
      $display("FAIL start6 got=%h/%b want=000105/1", if6.count, if6.running); end
    if6.start = 1'b0; if6.tick = 1'b1; if6.dir = 1'b0;
    step();
    total++; if (if6.count !== 24'h000104 || if6.done !== 1'b0) begin bad++;
      $display("FAIL down6_a got=%h/%b want=000104/0", if6.count, if6.done); end
    step();
    total++; if (if6.count !== 24'h000103 || if6.done !== 1'b0) begin bad++;
      $display("FAIL down6_b got=%h/%b want=000103/0", if6.count, if6.done); end
    step();
    total++; if (if6.count !== 24'h000102 || if6.done !== 1'b0) begin bad++;
      $display("FAIL down6_c got=%h/%b want=000102/0", if6.count, if6.done); end
    // Borrow across three digits.
    if6.tick = 1'b0; if6.load = 1'b1; if6.load_val = 24'h001000;
    step();
    if6.load = 1'b0; if6.start = 1'b1;
    step();
    if6.start = 1'b0; if6.tick = 1'b1;
    step();
    total++; if (if6.count !== 24'h000999) begin bad++;
      $display("FAIL borrow6 got=%h want=000999", if6.count); end
    if6.tick = 1'b0;
  endtask

  task automatic test_stop_done();
    if3.load = 1'b1; if3.load_val = 12'h002;
    step();
    if3.load = 1'b0; if3.start = 1'b1;
    step();
    if3.start = 1'b0; if3.tick = 1'b1;
    step();
    total++; if (if3.count !== 12'h001 || if3.done !== 1'b0) begin bad++;
      $display("FAIL done3_a got=%h/%b want=001/0", if3.count, if3.done); end
    step();
    total++; if (if3.count !== 12'h000 || if3.done !== 1'b1 || if3.running !== 1'b0) begin
      bad++; $display("FAIL done3_b got=%h/%b/%b want=000/1/0", if3.count, if3.done,
                      if3.running); end
    step();
    total++; if (if3.count !== 12'h000 || if3.done !== 1'b0) begin bad++;
      $display("FAIL done3_c got=%h/%b want=000/0", if3.count, if3.done); end
    // Restart at terminal: enters RUN, down-at-zero holds.
    if3.tick = 1'b0; if3.start = 1'b1;
    step();
    total++; if (if3.running !== 1'b1) begin bad++;
      $display("FAIL restart3 got=%b want=1", if3.running); end
    if3.start = 1'b0; if3.tick = 1'b1;
    step();
    total++; if (if3.count !== 12'h000 || if3.running !== 1'b0) begin bad++;
      $display("FAIL zero_hold got=%h/%b want=000/0", if3.count, if3.running); end
    if3.tick = 1'b0;
  endtask

  task automatic test_reload();
    if3r.load = 1'b1; if3r.load_val = 12'h001;
    step();
    if3r.load = 1'b0; if3r.start = 1'b1;
    step();
    if3r.start = 1'b0; if3r.tick = 1'b1;
    step();
    total++; if (if3r.count !== 12'h000 || if3r.done !== 1'b1 || if3r.running !== 1'b1) begin
      bad++; $display("FAIL reload_a got=%h/%b/%b want=000/1/1", if3r.count, if3r.done,
                      if3r.running); end
    step();
    total++; if (if3r.count !== 12'h001 || if3r.done !== 1'b0 || if3r.running !== 1'b1) begin
      bad++; $display("FAIL reload_b got=%h/%b/%b want=001/0/1", if3r.count, if3r.done,
                      if3r.running); end
    step();
    total++; if (if3r.count !== 12'h000 || if3r.done !== 1'b1) begin bad++;
      $display("FAIL reload_c got=%h/%b want=000/1", if3r.count, if3r.done); end
    if3r.tick = 1'b0;
  endtask

  task automatic test_up_wrap();
    int early;
    early = 0;
    if3.load = 1'b1; if3.load_val = 12'h998;
    step();
    if3.load = 1'b0; if3.start = 1'b1; if3.dir = 1'b1;
    step();
    if3.start = 1'b0; if3.tick = 1'b1;
    step();
    total++; if (if3.count !== 12'h999 || if3.done !== 1'b0) begin bad++;
      $display("FAIL up_a got=%h/%b want=999/0", if3.count, if3.done); end
    step();
    total++; if (if3.count !== 12'h000) begin bad++;
      $display("FAIL up_wrap got=%h want=000", if3.count); end
    step();
    total++; if (if3.count !== 12'h001) begin bad++;
      $display("FAIL up_b got=%h want=001", if3.count); end
    for (int k = 0; k < 997; k++) begin
      step();
      if (k < 996 && if3.done) early++;
      if (k == 98) begin
        total++; if (if3.count !== 12'h100) begin bad++;
          $display("FAIL up_carry got=%h want=100", if3.count); end
      end
    end
    total++; if (early !== 0) begin bad++;
      $display("FAIL up_early_done got=%0d want=0", early); end
    total++; if (if3.count !== 12'h998 || if3.done !== 1'b1 || if3.running !== 1'b0) begin
      bad++; $display("FAIL up_term got=%h/%b/%b want=998/1/0", if3.count, if3.done,
                      if3.running); end
    step();
    total++; if (if3.count !== 12'h998 || if3.done !== 1'b0) begin bad++;
      $display("FAIL up_hold got=%h/%b want=998/0", if3.count, if3.done); end
    if3.tick = 1'b0; if3.dir = 1'b0;
  endtask

  task automatic test_priority();
    if3.start = 1'b1;
    step();
    {if3.load, if3.stop, if3.start, if3.tick} = 4'b1111; if3.load_val = 12'h0F3;
    step();
    total++; if (if3.count !== 12'h093 || if3.running !== 1'b0) begin bad++;
      $display("FAIL prio_load got=%h/%b want=093/0", if3.count, if3.running); end
    {if3.load, if3.stop, if3.start, if3.tick} = 4'b0110;
    step();
    total++; if (if3.running !== 1'b0) begin bad++;
      $display("FAIL prio_stop_start got=%b want=0", if3.running); end
    {if3.load, if3.stop, if3.start, if3.tick} = 4'b0010;
    step();
    {if3.load, if3.stop, if3.start, if3.tick} = 4'b0101;
    step();
    total++; if (if3.running !== 1'b0 || if3.count !== 12'h093) begin bad++;
      $display("FAIL stop_run got=%h/%b want=093/0", if3.count, if3.running); end
    {if3.load, if3.stop, if3.start, if3.tick} = 4'b0001;
    step();
    total++; if (if3.count !== 12'h093) begin bad++;
      $display("FAIL idle_tick got=%h want=093", if3.count); end
    if3.tick = 1'b0;
  endtask

  task automatic test_async_reset();
    if6.load = 1'b1; if6.load_val = 24'h000451;
    step();
    if6.load = 1'b0; if6.start = 1'b1;
    step();
    if6.start = 1'b0; if6.tick = 1'b1;
    step();
    if6.tick = 1'b0;
    total++; if (if6.count !== 24'h000450 || if6.blank !== Blank450) begin bad++;
      $display("FAIL pre_rst got=%h/%b want=000450/%b", if6.count, if6.blank, Blank450); end
    #2 rst = 1'b0;
    #1;
    total++; if (if6.count !== 24'h0 || if6.running !== 1'b0) begin bad++;
      $display("FAIL async_rst got=%h/%b want=000000/0", if6.count, if6.running); end
    total++; if (if6.blank !== BlankZero6) begin bad++;
      $display("FAIL async_blank got=%b want=%b", if6.blank, BlankZero6); end
    @(negedge clk);
    rst = 1'b1;
    if3.load = 1'b1; if3.load_val = 12'h457;
    step();
    total++; if (if3.count !== 12'h457) begin bad++;
      $display("FAIL first_edge got=%h want=457", if3.count); end
    if3.load = 1'b0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_down6();
    test_stop_done();
    test_reload();
    test_up_wrap();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
